// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared definitions for the scoreboarded register file: default geometry,
// the number of hardwired constant registers, the index exported on ded_out,
// the address/data types at the default geometry, and a constant-register test.
package reg_file_pkg;

    localparam int unsigned DW_DEF      = 8;   // data width
    localparam int unsigned AW_DEF      = 3;   // address width, depth = 2**AW
    localparam int unsigned NCONST_DEF  = 2;   // r0..NCONST-1 read as their own index
    localparam int unsigned DED_REG_DEF = 2;   // register exported for branch/compare

    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [DW_DEF-1:0] reg_data_t;

    // True when addr names one of the hardwired constant registers.
    function automatic logic is_const(input logic [31:0] addr, input int unsigned nconst);
        return (addr < nconst);
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard
// Tracks the single outstanding memory load: whether one is pending, which
// register it targets (tag), and whether an ALU write to that register has
// superseded it (cancel). Produces the issue handshake, the per-read-port busy
// flags and the write enable/address used when the load data comes back.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_issue, ld_addr load issue request and destination register
//   ld_ret_valid      memory returns load data this cycle
//   alu_we, wr_addr   accepted (non-constant) ALU write and its address
//   rd_addr_a/b       read pointers for the busy flags
//   ld_ready          an issue is accepted this cycle
//   ld_pending        a load is outstanding
//   busy_a/b          register at rd_addr_a/b awaits a load
//   ld_we, ld_waddr   returned data must be written to register ld_waddr
module load_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NCONST = NCONST_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_ret_valid,
    input  logic          alu_we,
    input  logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          ld_ready,
    output logic          ld_pending,
    output logic          busy_a,
    output logic          busy_b,
    output logic          ld_we,
    output logic [AW-1:0] ld_waddr
);

    logic          pending_q, pending_d;
    logic [AW-1:0] tag_q,     tag_d;
    logic          cancel_q,  cancel_d;

    logic ret_fire;
    logic issue_acc;
    logic waw_hit;

    // A return in the same cycle frees the slot, so a new issue can ride on it.
    assign ld_ready  = !pending_q || ld_ret_valid;
    assign ret_fire  = ld_ret_valid && pending_q;
    assign issue_acc = ld_issue && ld_ready;
    // An ALU write that overtakes the load makes the returning data stale.
    assign waw_hit   = alu_we && pending_q && !ld_ret_valid && (wr_addr == tag_q);

    assign ld_pending = pending_q;
    assign ld_we      = ret_fire && !cancel_q && !is_const(32'(tag_q), NCONST);
    assign ld_waddr   = tag_q;

    assign busy_a = pending_q && !cancel_q && (tag_q == rd_addr_a)
                    && !is_const(32'(rd_addr_a), NCONST);
    assign busy_b = pending_q && !cancel_q && (tag_q == rd_addr_b)
                    && !is_const(32'(rd_addr_b), NCONST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pending_d = pending_q;
        tag_d     = tag_q;
        cancel_d  = cancel_q;
        if (issue_acc) begin
            // Any return this cycle completes against the old tag first.
            pending_d = 1'b1;
            tag_d     = ld_addr;
            cancel_d  = 1'b0;
        end else if (ret_fire) begin
            pending_d = 1'b0;
            cancel_d  = 1'b0;
        end else if (waw_hit) begin
            cancel_d  = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            tag_q     <= '0;
            cancel_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            tag_q     <= tag_d;
            cancel_q  <= cancel_d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Scoreboarded register file: two combinational read ports, a clocked ALU
// write port and a clocked load-return write port. Registers below NCONST are
// hardwired to their own index; register DED_REG is exported on ded_out.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   rd_addrA/B, datA/B_out         read pointers and combinational read data
//   busyA/B                        register at rd_addrA/B awaits a load
//   wr_en, wr_addr, wr_dat         ALU write port
//   ld_issue, ld_addr, ld_ready    load issue handshake
//   ld_ret_valid, ld_ret_dat       load return data
//   ld_pending                     a load is outstanding
//   ded_out                        registered contents of register DED_REG
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned NCONST  = NCONST_DEF,
    parameter int unsigned DED_REG = DED_REG_DEF,
    parameter int unsigned BYPASS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic          busyA,
    output logic          busyB,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_ready,
    input  logic          ld_ret_valid,
    input  logic [DW-1:0] ld_ret_dat,
    output logic          ld_pending,
    output logic [DW-1:0] ded_out
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] core_q [DEPTH];
    logic [DW-1:0] core_d [DEPTH];

    logic          alu_we;
    logic          ld_we;
    logic [AW-1:0] ld_waddr;

    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_dat  [2];

    // Writes aimed at the constant registers are dropped here, so neither
    // storage nor forwarding ever sees them.
    assign alu_we = wr_en && !is_const(32'(wr_addr), NCONST);

    load_scoreboard #(
        .AW     (AW),
        .NCONST (NCONST)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_issue     (ld_issue),
        .ld_addr      (ld_addr),
        .ld_ret_valid (ld_ret_valid),
        .alu_we       (alu_we),
        .wr_addr      (wr_addr),
        .rd_addr_a    (rd_addrA),
        .rd_addr_b    (rd_addrB),
        .ld_ready     (ld_ready),
        .ld_pending   (ld_pending),
        .busy_a       (busyA),
        .busy_b       (busyB),
        .ld_we        (ld_we),
        .ld_waddr     (ld_waddr)
    );

    // Write mux: the load return is applied last so it wins a same-register
    // collision with the ALU write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            core_d[i] = core_q[i];
        end
        if (alu_we) begin
            core_d[wr_addr] = wr_dat;
        end
        if (ld_we) begin
            core_d[ld_waddr] = ld_ret_dat;
        end
    end

    // NOTE: the array is reset explicitly because software relies on every
    // writable register reading 0 after reset; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                core_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                core_q[i] <= core_d[i];
            end
        end
    end

    assign rd_addr[0] = rd_addrA;
    assign rd_addr[1] = rd_addrB;

    // Read ports: constants first, then same-cycle forwarding (load data ahead
    // of ALU data), then stored contents.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = core_q[rd_addr[p]];
            if (is_const(32'(rd_addr[p]), NCONST)) begin
                rd_dat[p] = DW'(rd_addr[p]);
            end else if (BYPASS != 0) begin
                if (ld_we && (ld_waddr == rd_addr[p])) begin
                    rd_dat[p] = ld_ret_dat;
                end else if (alu_we && (wr_addr == rd_addr[p])) begin
                    rd_dat[p] = wr_dat;
                end
            end
        end
    end

    assign datA_out = rd_dat[0];
    assign datB_out = rd_dat[1];
    assign ded_out  = core_q[AW'(DED_REG)];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Self-checking bench for reg_file_sb at its default parameters: a table of
// directed vectors, hand-written reset sequences, and a randomized phase
// checked against a behavioural model of the register file and its load slot.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_addr_t rd_addrA, rd_addrB, wr_addr, ld_addr;
    reg_data_t datA_out, datB_out, wr_dat, ld_ret_dat, ded_out;
    logic      busyA, busyB, wr_en, ld_issue, ld_ready, ld_ret_valid, ld_pending;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addrA     (rd_addrA),
        .rd_addrB     (rd_addrB),
        .datA_out     (datA_out),
        .datB_out     (datB_out),
        .busyA        (busyA),
        .busyB        (busyB),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_dat       (wr_dat),
        .ld_issue     (ld_issue),
        .ld_addr      (ld_addr),
        .ld_ready     (ld_ready),
        .ld_ret_valid (ld_ret_valid),
        .ld_ret_dat   (ld_ret_dat),
        .ld_pending   (ld_pending),
        .ded_out      (ded_out)
    );

    typedef struct {
        logic      we;  reg_addr_t wa; reg_data_t wd;
        logic      li;  reg_addr_t la;
        logic      rv;  reg_data_t rdat;
        reg_addr_t ra;  reg_addr_t rb;
        reg_data_t da;  reg_data_t db;
        logic      ba;  logic bb; logic rdy; logic pend;
        reg_data_t ded;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input reg_addr_t wa, input reg_data_t wd,
                                input logic li, input reg_addr_t la,
                                input logic rv, input reg_data_t rdat,
                                input reg_addr_t ra, input reg_addr_t rb,
                                input reg_data_t da, input reg_data_t db,
                                input logic ba, input logic bb, input logic rdy,
                                input logic pend, input reg_data_t ded);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.li = li; v.la = la;
        v.rv = rv; v.rdat = rdat; v.ra = ra; v.rb = rb;
        v.da = da; v.db = db; v.ba = ba; v.bb = bb; v.rdy = rdy; v.pend = pend; v.ded = ded;
        return v;
    endfunction

    task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                         input logic li, input reg_addr_t la,
                         input logic rv, input reg_data_t rdat,
                         input reg_addr_t ra, input reg_addr_t rb);
        wr_en = we; wr_addr = wa; wr_dat = wd;
        ld_issue = li; ld_addr = la;
        ld_ret_valid = rv; ld_ret_dat = rdat;
        rd_addrA = ra; rd_addrB = rb;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reads every address on port A (and the reverse on port B) against the
    // post-reset contents: constants read their index, all others read 0.
    task automatic check_all_cleared(input string tag);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            idle();
            rd_addrA = reg_addr_t'(a);
            rd_addrB = reg_addr_t'(7 - a);
            #1;
            check($sformatf("%s rdA[%0d]", tag, a), 32'(datA_out), (a < 2) ? a : 0);
            check($sformatf("%s rdB[%0d]", tag, 7 - a), 32'(datB_out), ((7 - a) < 2) ? (7 - a) : 0);
        end
    endtask

    // Behavioural model: register contents plus the single outstanding load,
    // recorded as its destination and whether a later ALU write overtook it.
    int  m_reg [8];
    bit  m_pend;
    int  m_dest;
    bit  m_killed;

    function automatic bit m_ret_writes(input bit rv);
        return rv && m_pend && !m_killed && (m_dest >= 2);
    endfunction

    function automatic int m_read(input int a, input bit we, input int wa, input int wd,
                                  input bit rv, input int rdat);
        if (a < 2) return a;
        if (m_ret_writes(rv) && m_dest == a) return rdat;
        if (we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic bit m_busy(input int a);
        return m_pend && !m_killed && (m_dest == a) && (a >= 2);
    endfunction

    task automatic m_step(input bit we, input int wa, input int wd, input bit li, input int la,
                          input bit rv, input int rdat);
        bit ready;
        ready = !m_pend || rv;
        if (we && wa >= 2) m_reg[wa] = wd;
        if (m_ret_writes(rv)) m_reg[m_dest] = rdat;
        if (we && wa >= 2 && m_pend && !rv && wa == m_dest) m_killed = 1;
        if (li && ready) begin
            m_pend = 1; m_dest = la; m_killed = 0;
        end else if (rv && m_pend) begin
            m_pend = 0;
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state: handshake and exported register.
        #1;
        check("rst busyA", 32'(busyA), 0);
        check("rst busyB", 32'(busyB), 0);
        check("rst ld_ready", 32'(ld_ready), 1);
        check("rst ld_pending", 32'(ld_pending), 0);
        check("rst ded_out", 32'(ded_out), 0);
        check_all_cleared("rst");

        //         we wa  wd     li la rv rdat   ra rb  da     db     ba bb rdy pnd ded
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'hFF, 0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 5, 8'h3C, 0, 0, 0, 8'h00, 5, 0, 8'h3C, 8'h00, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 2, 8'h3C, 8'h00, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 2, 8'hA5, 0, 0, 0, 8'h00, 2, 5, 8'hA5, 8'h3C, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 2, 5, 8'hA5, 8'h3C, 0, 0, 1, 0, 8'hA5));
        // Load to r4, ignored second issue, return 0x77.
        tbl.push_back(mk(0, 0, 8'h00, 1, 4, 0, 8'h00, 4, 5, 8'h00, 8'h3C, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 1, 6, 0, 8'h00, 4, 6, 8'h00, 8'h00, 1, 0, 0, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h77, 4, 6, 8'h77, 8'h00, 1, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 4, 6, 8'h77, 8'h00, 0, 0, 1, 0, 8'hA5));
        // WAW cancel on r3.
        tbl.push_back(mk(0, 0, 8'h00, 1, 3, 0, 8'h00, 3, 4, 8'h00, 8'h77, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(1, 3, 8'h11, 0, 0, 0, 8'h00, 3, 4, 8'h11, 8'h77, 1, 0, 0, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 3, 4, 8'h11, 8'h77, 0, 0, 0, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h99, 3, 4, 8'h11, 8'h77, 0, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 3, 4, 8'h11, 8'h77, 0, 0, 1, 0, 8'hA5));
        // ALU and load return to the same register: load data wins.
        tbl.push_back(mk(0, 0, 8'h00, 1, 6, 0, 8'h00, 6, 7, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(1, 6, 8'h01, 0, 0, 1, 8'h02, 6, 7, 8'h02, 8'h00, 1, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 6, 7, 8'h02, 8'h00, 0, 0, 1, 0, 8'hA5));
        // Return to r4 alongside ALU write to r7: both land.
        tbl.push_back(mk(0, 0, 8'h00, 1, 4, 0, 8'h00, 4, 7, 8'h77, 8'h00, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(1, 7, 8'h5A, 0, 0, 1, 8'hC3, 4, 7, 8'hC3, 8'h5A, 1, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 4, 7, 8'hC3, 8'h5A, 0, 0, 1, 0, 8'hA5));
        // Return to r5 and new issue to r7 in the same cycle.
        tbl.push_back(mk(0, 0, 8'h00, 1, 5, 0, 8'h00, 5, 0, 8'h3C, 8'h00, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 1, 7, 1, 8'hE1, 5, 7, 8'hE1, 8'h5A, 1, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 7, 8'hE1, 8'h5A, 0, 1, 0, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h0F, 5, 7, 8'hE1, 8'h0F, 0, 1, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 5, 7, 8'hE1, 8'h0F, 0, 0, 1, 0, 8'hA5));
        // Load targeting a constant register: never busy, never written.
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 2, 8'h01, 8'hA5, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h44, 1, 2, 8'h01, 8'hA5, 0, 0, 1, 1, 8'hA5));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 2, 8'h01, 8'hA5, 0, 0, 1, 0, 8'hA5));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].li, tbl[i].la,
                  tbl[i].rv, tbl[i].rdat, tbl[i].ra, tbl[i].rb);
            #1;
            check($sformatf("v%0d datA", i), 32'(datA_out), 32'(tbl[i].da));
            check($sformatf("v%0d datB", i), 32'(datB_out), 32'(tbl[i].db));
            check($sformatf("v%0d busyA", i), 32'(busyA), 32'(tbl[i].ba));
            check($sformatf("v%0d busyB", i), 32'(busyB), 32'(tbl[i].bb));
            check($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(tbl[i].rdy));
            check($sformatf("v%0d ld_pending", i), 32'(ld_pending), 32'(tbl[i].pend));
            check($sformatf("v%0d ded_out", i), 32'(ded_out), 32'(tbl[i].ded));
        end

        // Reset mid-load: pending state clears asynchronously and a late
        // return afterwards writes nothing.
        @(negedge clk);
        drive(0, 0, 0, 1, 5, 0, 0, 5, 0);
        @(negedge clk);
        idle();
        rd_addrA = 3'd5;
        #1;
        check("midld busyA before", 32'(busyA), 1);
        check("midld pending before", 32'(ld_pending), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midld busyA async", 32'(busyA), 0);
        check("midld pending async", 32'(ld_pending), 0);
        check("midld ready async", 32'(ld_ready), 1);
        check("midld ded async", 32'(ded_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 8'hAA, 5, 0);
        #1;
        check("midld late ret pending", 32'(ld_pending), 0);
        check_all_cleared("postrst");

        // Randomized phase against the behavioural model, from a fresh reset.
        for (int a = 0; a < 8; a++) m_reg[a] = 0;
        m_pend = 0; m_dest = 0; m_killed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit we, li, rv;
            int wa, wd, la, rdat, ra, rb;
            we   = ($urandom_range(1, 0) == 1);
            li   = ($urandom_range(2, 0) == 0);
            rv   = ($urandom_range(2, 0) == 0);
            wa   = $urandom_range(7, 0);
            la   = $urandom_range(7, 0);
            ra   = $urandom_range(7, 0);
            rb   = $urandom_range(7, 0);
            wd   = $urandom_range(255, 0);
            rdat = $urandom_range(255, 0);
            @(negedge clk);
            drive(we, reg_addr_t'(wa), reg_data_t'(wd), li, reg_addr_t'(la),
                  rv, reg_data_t'(rdat), reg_addr_t'(ra), reg_addr_t'(rb));
            #1;
            check("rnd datA", 32'(datA_out), m_read(ra, we, wa, wd, rv, rdat));
            check("rnd datB", 32'(datB_out), m_read(rb, we, wa, wd, rv, rdat));
            check("rnd busyA", 32'(busyA), 32'(m_busy(ra)));
            check("rnd busyB", 32'(busyB), 32'(m_busy(rb)));
            check("rnd ld_ready", 32'(ld_ready), 32'(!m_pend || rv));
            check("rnd ld_pending", 32'(ld_pending), 32'(m_pend));
            check("rnd ded_out", 32'(ded_out), m_reg[2]);
            m_step(we, wa, wd, li, la, rv, rdat);
        end

        @(negedge clk);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
